// File: rtl/vp_mode_top.sv
// vp_mode_top
// Runtime-selectable pixel-mode engine between the RGB444 camera stream and
// the frame-buffer writer. Each pixel is converted to a DW-bit value using
// grayscale, binary threshold, inverted grayscale or max-channel mode. Mode
// and threshold are latched on the first pixel of each frame so a frame is
// never mixed-mode. Two-stage pipeline with ready/valid on both sides.
//
// Parameters
//   DW  output pixel width (4..8)
//   RL  pixels per row
//   NR  rows per frame
// Ports
//   i_clk         clock
//   i_rstn        asynchronous active-low reset
//   i_mode        requested mode (0 gray, 1 threshold, 2 inverted, 3 max)
//   i_threshold   requested binary threshold
//   o_data_ready  stage accepts an input beat
//   i_data_valid  input beat valid
//   i_data        RGB444 pixel {R,G,B}
//   i_data_ready  downstream accepts an output beat
//   o_data_valid  output beat valid
//   o_data        processed pixel
//   o_sof         first pixel of a frame
//   o_eol         last pixel of a row
//   o_mode        mode currently applied
module vp_mode_top #(
  parameter int DW = 8,
  parameter int RL = 640,
  parameter int NR = 480
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [1:0]    i_mode,
  input  logic [7:0]    i_threshold,
  output logic          o_data_ready,
  input  logic          i_data_valid,
  input  logic [11:0]   i_data,
  input  logic          i_data_ready,
  output logic          o_data_valid,
  output logic [DW-1:0] o_data,
  output logic          o_sof,
  output logic          o_eol,
  output logic [1:0]    o_mode
);

  localparam int CW = (RL > 1) ? $clog2(RL) : 1;
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_THR  = 2'd1,
    MODE_INV  = 2'd2,
    MODE_MAX  = 2'd3
  } mode_e;

  // Frame position and per-frame latched controls
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  mode_e         mode_q;
  logic [7:0]    thr_q;

  // Stage 1 registers
  logic          s1_valid_q;
  logic [7:0]    s1_gray_q;
  logic [3:0]    s1_max_q;
  mode_e         s1_mode_q;
  logic [7:0]    s1_thr_q;
  logic          s1_sof_q;
  logic          s1_eol_q;

  // Handshake
  logic advance;
  logic accept;

  assign advance      = !o_data_valid || i_data_ready;
  assign o_data_ready = advance;
  assign accept       = i_data_valid && advance;

  // Frame position decode
  logic first_px;
  logic last_col;
  logic last_row;

  assign first_px = (col_q == '0) && (row_q == '0);
  assign last_col = (col_q == CW'(RL - 1));
  assign last_row = (row_q == RW'(NR - 1));

  // The SOF beat must already use the newly requested controls, so bypass
  // the latch on that beat instead of waiting a cycle for mode_q/thr_q.
  mode_e      eff_mode;
  logic [7:0] eff_thr;

  assign eff_mode = first_px ? mode_e'(i_mode) : mode_q;
  assign eff_thr  = first_px ? i_threshold     : thr_q;

  // Stage 1 arithmetic
  logic [3:0] px_r, px_g, px_b;
  logic [7:0] sum;
  logic [7:0] gray_d;
  logic [3:0] max_d;

  assign px_r = i_data[11:8];
  assign px_g = i_data[7:4];
  assign px_b = i_data[3:0];

  // 5R + 9G + 2B peaks at 240, and adding sum>>4 peaks at 255: 8 bits suffice.
  assign sum    = (8'(px_r) * 8'd5) + (8'(px_g) * 8'd9) + (8'(px_b) * 8'd2);
  assign gray_d = sum + {4'b0000, sum[7:4]};

  always_comb begin
    max_d = px_r;
    if (px_g > max_d) max_d = px_g;
    if (px_b > max_d) max_d = px_b;
  end

  // Stage 2 mode selection
  logic [DW-1:0] data_d;
  logic [7:0]    max8;

  always_comb begin
    data_d = '0;
    max8   = {s1_max_q, s1_max_q};
    case (s1_mode_q)
      MODE_GRAY: data_d = s1_gray_q[7 -: DW];
      MODE_THR:  data_d = (s1_gray_q >= s1_thr_q) ? '1 : '0;
      MODE_INV:  data_d = ~s1_gray_q[7 -: DW];
      MODE_MAX:  data_d = max8[7 -: DW];
      default:   data_d = '0;
    endcase
  end

  // Frame counters and control latch
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= MODE_GRAY;
      thr_q  <= '0;
    end else if (accept) begin
      if (first_px) begin
        mode_q <= mode_e'(i_mode);
        thr_q  <= i_threshold;
      end
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Pipeline: both stages move together on advance; bubbles travel as
  // cleared valid bits.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid_q   <= 1'b0;
      s1_gray_q    <= '0;
      s1_max_q     <= '0;
      s1_mode_q    <= MODE_GRAY;
      s1_thr_q     <= '0;
      s1_sof_q     <= 1'b0;
      s1_eol_q     <= 1'b0;
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_sof        <= 1'b0;
      o_eol        <= 1'b0;
    end else if (advance) begin
      s1_valid_q   <= i_data_valid;
      s1_gray_q    <= gray_d;
      s1_max_q     <= max_d;
      s1_mode_q    <= eff_mode;
      s1_thr_q     <= eff_thr;
      s1_sof_q     <= first_px;
      s1_eol_q     <= last_col;
      o_data_valid <= s1_valid_q;
      o_data       <= data_d;
      o_sof        <= s1_sof_q;
      o_eol        <= s1_eol_q;
    end
  end

  assign o_mode = mode_q;

endmodule

// File: tb/tb_vp_mode_top.sv
module tb_vp_mode_top;

  localparam int RL = 8;
  localparam int NR = 4;
  localparam int FR = RL * NR;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  mode;
  logic [7:0]  thr;
  logic        dvalid;
  logic [11:0] din;
  logic        dready;

  logic        rdy8, ov8, sof8, eol8;
  logic [7:0]  od8;
  logic [1:0]  om8;
  logic        rdy4, ov4, sof4, eol4;
  logic [3:0]  od4;
  logic [1:0]  om4;

  always #5 clk = ~clk;

  vp_mode_top #(.DW(8), .RL(RL), .NR(NR)) u_dut8 (
    .i_clk(clk), .i_rstn(rstn), .i_mode(mode), .i_threshold(thr),
    .o_data_ready(rdy8), .i_data_valid(dvalid), .i_data(din),
    .i_data_ready(dready), .o_data_valid(ov8), .o_data(od8),
    .o_sof(sof8), .o_eol(eol8), .o_mode(om8)
  );

  vp_mode_top #(.DW(4), .RL(RL), .NR(NR)) u_dut4 (
    .i_clk(clk), .i_rstn(rstn), .i_mode(mode), .i_threshold(thr),
    .o_data_ready(rdy4), .i_data_valid(dvalid), .i_data(din),
    .i_data_ready(dready), .o_data_valid(ov4), .o_data(od4),
    .o_sof(sof4), .o_eol(eol4), .o_mode(om4)
  );

  typedef struct {
    logic [7:0] d8;
    logic [3:0] d4;
    logic       sof;
    logic       eol;
    int         cyc;
  } exp_t;

  exp_t q[$];

  int         cmp_cnt = 0;
  int         fail_cnt = 0;
  int         cyc = 0;
  int         idx = 0;
  logic [1:0] f_mode = 2'd0;
  logic [7:0] f_thr = 8'd0;
  logic [1:0] exp_omode = 2'd0;
  bit         strict_lat = 1'b1;
  bit         bp_mode = 1'b0;
  int         forced_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: luma ~ (5R+9G+2B)*17/16 on 4-bit channels, scaled to 8 bits.
  function automatic logic [7:0] model8(input logic [1:0] m, input logic [7:0] t,
                                        input logic [11:0] p);
    int r, g, b, y, mx;
    r  = int'(p[11:8]);
    g  = int'(p[7:4]);
    b  = int'(p[3:0]);
    y  = ((5 * r + 9 * g + 2 * b) * 17) / 16;
    mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    case (m)
      2'd0:    return 8'(y);
      2'd1:    return (y >= int'(t)) ? 8'hFF : 8'h00;
      2'd2:    return 8'(255 - y);
      default: return 8'(mx * 17);
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Input side: record each accepted beat into the scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      exp_t e;
      check("o_mode", 32'(om8), 32'(exp_omode));
      check("o_mode_dw4", 32'(om4), 32'(exp_omode));
      check("ready_rule", 32'(rdy8), 32'(!ov8 || dready));
      if (dvalid && rdy8) begin
        if (idx == 0) begin
          f_mode    = mode;
          f_thr     = thr;
          exp_omode = mode;
        end
        e.d8  = model8(f_mode, f_thr, din);
        e.d4  = e.d8[7:4];
        e.sof = (idx == 0);
        e.eol = ((idx % RL) == RL - 1);
        e.cyc = cyc;
        q.push_back(e);
        idx = (idx + 1) % FR;
      end
    end
  end

  // Output side: pop and compare on every delivered beat; check hold on stall
  bit         stall_prev = 1'b0;
  logic [7:0] h_d8;
  logic [3:0] h_d4;
  logic       h_sof, h_eol;

  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(ov8), 32'd1);
        check("hold_data", 32'(od8), 32'(h_d8));
        check("hold_data4", 32'(od4), 32'(h_d4));
        check("hold_sof", 32'(sof8), 32'(h_sof));
        check("hold_eol", 32'(eol8), 32'(h_eol));
      end
      if (ov8 && dready) begin
        if (q.size() == 0) begin
          cmp_cnt++;
          fail_cnt++;
          $display("FAIL unexpected_output: got %0h expected none", od8);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("data", 32'(od8), 32'(e.d8));
          check("data_dw4", 32'(od4), 32'(e.d4));
          check("sof", 32'(sof8), 32'(e.sof));
          check("eol", 32'(eol8), 32'(e.eol));
          if (strict_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
      stall_prev = ov8 && !dready;
      h_d8  = od8;
      h_d4  = od4;
      h_sof = sof8;
      h_eol = eol8;
    end
  end

  // Downstream ready generator
  initial begin
    dready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (forced_stall > 0) begin
        dready = 1'b0;
        forced_stall--;
      end else if (bp_mode) begin
        dready = 1'($urandom_range(0, 1));
      end else begin
        dready = 1'b1;
      end
    end
  end

  task automatic send(input logic [11:0] p, input int gap);
    bit ok;
    int t;
    for (int i = 0; i < gap; i++) begin
      dvalid = 1'b0;
      din    = 12'($urandom);
      @(posedge clk);
      #1;
    end
    dvalid = 1'b1;
    din    = p;
    ok     = 1'b0;
    t      = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (rdy8) ok = 1'b1;
      t++;
    end
    if (!ok) begin
      cmp_cnt++;
      fail_cnt++;
      $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", t);
    end
    @(posedge clk);
    #1;
    dvalid = 1'b0;
  endtask

  task automatic send_rand(input int n, input int gapmax);
    for (int i = 0; i < n; i++) send(12'($urandom), $urandom_range(0, gapmax));
  endtask

  initial begin
    rstn   = 1'b0;
    dvalid = 1'b0;
    din    = '0;
    mode   = 2'd0;
    thr    = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(ov8), 32'd0);
    check("rst_data", 32'(od8), 32'd0);
    check("rst_sof", 32'(sof8), 32'd0);
    check("rst_eol", 32'(eol8), 32'd0);
    check("rst_mode", 32'(om8), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(rdy8), 32'd1);
    @(posedge clk);
    #1;

    // Frame 0: gray, request inverted at pixel 10 (takes effect next frame)
    mode = 2'd0;
    send(12'hFFF, 0);
    send(12'h000, 0);
    send(12'hF00, 0);
    send(12'h0F0, 0);
    for (int p = 4; p < FR; p++) begin
      if (p == 10) mode = 2'd2;
      send(12'($urandom), $urandom_range(0, 2));
    end

    // Frame 1: inverted gray
    send_rand(FR, 1);

    // Frame 2: threshold 0x50, mid-frame changes ignored
    mode = 2'd1;
    thr  = 8'h50;
    send(12'hF00, 0);
    send(12'h0F0, 0);
    send(12'h555, 0);
    send_rand(5, 1);
    mode = 2'd0;
    thr  = 8'($urandom);
    send_rand(FR - 8, 1);

    // Frame 3: max-channel
    mode = 2'd3;
    send(12'h3A5, 0);
    send(12'hFFF, 0);
    send_rand(FR - 2, 1);

    // Random backpressure frames with random mode requests
    strict_lat = 1'b0;
    bp_mode    = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < FR; p++) begin
        if ($urandom_range(0, 7) == 0) begin
          mode = 2'($urandom);
          thr  = 8'($urandom);
        end
        if (f == 1 && p == 12) forced_stall = 5;
        send(12'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
      end
    end

    // Mid-frame reset with beats in flight
    send_rand(13, 0);
    dvalid  = 1'b1;
    din     = 12'($urandom);
    bp_mode = 1'b0;
    rstn    = 1'b0;
    #1;
    check("midrst_valid", 32'(ov8), 32'd0);
    check("midrst_mode", 32'(om8), 32'd0);
    check("midrst_sof", 32'(sof8), 32'd0);
    q.delete();
    idx        = 0;
    exp_omode  = 2'd0;
    dvalid     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn       = 1'b1;
    strict_lat = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", 32'(rdy8), 32'd1);
    @(posedge clk);
    #1;
    mode = 2'd3;
    send(12'h3A5, 0);
    mode = 2'd0;
    send_rand(FR + 5, 1);

    // Drain
    begin
      int t;
      t = 0;
      while (q.size() != 0 && t < 100) begin
        @(posedge clk);
        t++;
      end
      if (q.size() != 0) begin
        cmp_cnt++;
        fail_cnt++;
        $display("FAIL drain_timeout: got %0d pending beats, expected 0", q.size());
      end
    end
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
